// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache; hits answer combinationally, misses refill the line word by word.
// rdy_in low freezes all state; clear during a refill abandons the line once the outstanding word returns.
module instruction_cache #(
    parameter int INDEX_BITS     = 6,
    parameter int LINE_WORDS_LOG = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] fetch_addr,
    input  logic        clear,
    output logic        ready_out,
    output logic [31:0] inst_out,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << LINE_WORDS_LOG;
    localparam int IDX_LO   = LINE_WORDS_LOG + 2;
    localparam int TAG_LO   = IDX_LO + INDEX_BITS;
    localparam int TAG_BITS = 32 - TAG_LO;

    typedef enum logic {S_IDLE, S_REFILL} state_t;

    state_t                      state_q, state_d;
    logic [LINES-1:0]            valid_q, valid_d;
    logic [LINE_WORDS_LOG-1:0]   cnt_q, cnt_d;
    logic                        mem_req_q, mem_req_d;
    logic [31:0]                 mem_addr_q, mem_addr_d;
    logic                        abort_q, abort_d;
    logic [INDEX_BITS-1:0]       line_idx_q, line_idx_d;
    logic [TAG_BITS-1:0]         line_tag_q, line_tag_d;

    logic [TAG_BITS-1:0]         tag_mem  [LINES];
    logic [31:0]                 data_mem [LINES*WORDS];

    logic                              data_we;
    logic                              tag_we;
    logic [INDEX_BITS+LINE_WORDS_LOG-1:0] data_waddr;

    logic [LINE_WORDS_LOG-1:0]   fetch_off;
    logic [INDEX_BITS-1:0]       fetch_idx;
    logic [TAG_BITS-1:0]         fetch_tag;
    logic                        hit;
    logic                        unused_addr_lsb;

    assign fetch_off       = fetch_addr[IDX_LO-1:2];
    assign fetch_idx       = fetch_addr[TAG_LO-1:IDX_LO];
    assign fetch_tag       = fetch_addr[31:TAG_LO];
    assign unused_addr_lsb = ^fetch_addr[1:0];

    // valid_q clears asynchronously, so a hit cannot appear while reset is held.
    assign hit       = (state_q == S_IDLE) && valid_q[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
    assign ready_out = hit && rdy_in && !clear;
    assign inst_out  = ready_out ? data_mem[{fetch_idx, fetch_off}] : 32'd0;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        abort_d    = abort_q;
        line_idx_d = line_idx_q;
        line_tag_d = line_tag_q;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        data_waddr = {line_idx_q, cnt_q};

        case (state_q)
            S_IDLE: begin
                if (rdy_in && !clear && !hit) begin
                    line_idx_d          = fetch_idx;
                    line_tag_d          = fetch_tag;
                    valid_d[fetch_idx]  = 1'b0;
                    cnt_d               = '0;
                    abort_d             = 1'b0;
                    mem_req_d           = 1'b1;
                    mem_addr_d          = {fetch_tag, fetch_idx, {(LINE_WORDS_LOG+2){1'b0}}};
                    state_d             = S_REFILL;
                end
            end
            S_REFILL: begin
                if (rdy_in) begin
                    if (mem_ack) begin
                        data_we = 1'b1;
                        // An aborted line is left invalid; the last word in flight is simply drained.
                        if (abort_q || clear) begin
                            abort_d   = 1'b0;
                            mem_req_d = 1'b0;
                            state_d   = S_IDLE;
                        end else if (cnt_q == '1) begin
                            valid_d[line_idx_q] = 1'b1;
                            tag_we              = 1'b1;
                            mem_req_d           = 1'b0;
                            state_d             = S_IDLE;
                        end else begin
                            cnt_d      = cnt_q + 1'b1;
                            mem_addr_d = mem_addr_q + 32'd4;
                        end
                    end else if (clear) begin
                        abort_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
            abort_q    <= 1'b0;
            line_idx_q <= '0;
            line_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            abort_q    <= abort_d;
            line_idx_q <= line_idx_d;
            line_tag_q <= line_tag_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (data_we) begin
            data_mem[data_waddr] <= mem_data;
        end
        if (tag_we) begin
            tag_mem[line_idx_q] <= line_tag_q;
        end
    end
endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a small alternating-ack memory model.
module tb_instruction_cache;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] fetch_addr;
    logic        clear;
    logic        ready_out;
    logic [31:0] inst_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    int          errors = 0;
    int          checks = 0;
    bit          auto_mem = 1'b1;
    logic [31:0] acc_q[$];

    instruction_cache dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .fetch_addr (fetch_addr),
        .clear      (clear),
        .ready_out  (ready_out),
        .inst_out   (inst_out),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + (a >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory answers every other cycle while a request is pending.
    task automatic tick();
        @(posedge clk_in);
        #1;
        if (auto_mem) begin
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req && rdy_in) begin
                mem_ack  = 1'b1;
                mem_data = mem_word(mem_addr);
                acc_q.push_back(mem_addr);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && mem_req; i++) tick();
        check(tag, 32'(mem_req), 32'd0);
    endtask

    task automatic check_seq(input string tag, input logic [31:0] base, input int n);
        check({tag, "_n"}, acc_q.size(), n);
        for (int i = 0; i < n; i++)
            check({tag, "_a"}, (i < acc_q.size()) ? acc_q[i] : 32'hFFFF_FFFF, base + 32'(4 * i));
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
        mem_ack = 1'b0; mem_data = 32'd0; fetch_addr = 32'd0;
        #12;
        check("rst_req",   32'(mem_req),   32'd0);
        check("rst_addr",  mem_addr,       32'd0);
        check("rst_ready", 32'(ready_out), 32'd0);
        check("rst_inst",  inst_out,       32'd0);
        rst_in = 1'b0;
        #1;

        // Test 1: cold miss at 0x0
        check("t1_miss", 32'(ready_out), 32'd0);
        tick();
        check("t1_req",  32'(mem_req), 32'd1);
        check("t1_addr", mem_addr,     32'h0);
        wait_idle("t1_done");
        check_seq("t1", 32'h0, 4);
        check("t1_ready", 32'(ready_out), 32'd1);
        check("t1_inst",  inst_out,       32'hA0);

        // Test 2: same-line hit
        fetch_addr = 32'h8;
        #1;
        check("t2_ready", 32'(ready_out), 32'd1);
        check("t2_inst",  inst_out,       32'hA2);
        tick();
        check("t2_noreq", 32'(mem_req), 32'd0);

        // clear in IDLE: hit suppressed, miss not started
        fetch_addr = 32'h0; clear = 1'b1;
        #1;
        check("clr_ready", 32'(ready_out), 32'd0);
        check("clr_inst",  inst_out,       32'd0);
        fetch_addr = 32'h200;
        tick();
        tick();
        check("clr_noreq", 32'(mem_req), 32'd0);
        clear = 1'b0;

        // Test 3: conflict miss on index 0
        acc_q.delete();
        fetch_addr = 32'h400;
        #1;
        check("t3_miss", 32'(ready_out), 32'd0);
        tick();
        wait_idle("t3_done");
        check_seq("t3", 32'h400, 4);
        check("t3_inst", inst_out, 32'h1A0);
        fetch_addr = 32'h0;
        #1;
        check("t3_evict", 32'(ready_out), 32'd0);
        tick();
        check("t3_req",  32'(mem_req), 32'd1);
        check("t3_addr", mem_addr,     32'h0);
        wait_idle("t3_done2");

        // Test 4: clear between 2nd and 3rd ack
        acc_q.delete();
        fetch_addr = 32'h40;
        tick();
        tick();
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        check("t4_drop",  32'(mem_req),   32'd0);
        check("t4_inval", 32'(ready_out), 32'd0);
        check_seq("t4", 32'h40, 3);
        tick();
        check("t4_restart", 32'(mem_req), 32'd1);
        check("t4_readdr",  mem_addr,     32'h40);
        wait_idle("t4_done");
        check("t4_inst", inst_out, 32'hB0);

        // rdy_in low in IDLE: no miss started
        fetch_addr = 32'hC0; rdy_in = 1'b0;
        #1;
        check("frz_ready", 32'(ready_out), 32'd0);
        tick();
        check("frz_noreq", 32'(mem_req), 32'd0);

        // Test 5: freeze mid-refill with ack pulsed
        auto_mem = 1'b0;
        mem_ack = 1'b0;
        fetch_addr = 32'h80; rdy_in = 1'b1;
        tick();
        check("t5_addr0", mem_addr, 32'h80);
        mem_ack = 1'b1; mem_data = mem_word(32'h80);
        tick();
        mem_ack = 1'b0;
        rdy_in = 1'b0; mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_frz_addr", mem_addr,     32'h84);
            check("t5_frz_req",  32'(mem_req), 32'd1);
        end
        rdy_in = 1'b1; mem_ack = 1'b0;
        tick();
        check("t5_hold_addr", mem_addr, 32'h84);
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1; mem_data = mem_word(mem_addr);
            tick();
            mem_ack = 1'b0;
        end
        check("t5_done",  32'(mem_req),   32'd0);
        check("t5_ready", 32'(ready_out), 32'd1);
        check("t5_w0",    inst_out,       32'hC0);
        fetch_addr = 32'h84;
        #1;
        check("t5_w1", inst_out, 32'hC1);
        auto_mem = 1'b1;

        // Test 6: async reset mid-refill
        fetch_addr = 32'h100;
        tick();
        tick();
        check("t6_busy", 32'(mem_req), 32'd1);
        #2;
        rst_in = 1'b1;
        #1;
        check("t6_req",  32'(mem_req),   32'd0);
        check("t6_addr", mem_addr,       32'd0);
        fetch_addr = 32'h0;
        #3;
        rst_in = 1'b0;
        #1;
        check("t6_miss", 32'(ready_out), 32'd0);
        tick();
        check("t6_rereq",  32'(mem_req), 32'd1);
        check("t6_readdr", mem_addr,     32'h0);
        wait_idle("t6_done");
        check("t6_inst", inst_out, 32'hA0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
